// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the single-port memory arbiter.
package mem_arb_pkg;

    localparam int DEF_DATA = 8;
    localparam int DEF_ADDR = 16;
    localparam int DEF_NREQ = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_select.sv
// Combinational winner search: first set req above ptr, wrapping modulo NREQ.
module arb_select
    import mem_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] gnt_oh,
    output logic [IDXW-1:0] gnt_idx
);

    localparam int unsigned N = NREQ;

    int unsigned     cand;
    logic [IDXW-1:0] cidx;
    logic            found;

    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = 0;
        cidx    = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = (32'(ptr) + k) % N;
            cidx = IDXW'(cand);
            if (!found && req[cidx]) begin
                found         = 1'b1;
                gnt_oh[cidx]  = 1'b1;
                gnt_idx       = cidx;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates NREQ requesters onto one memory read/write port (IDLE/ISSUE/RESP).
// Define ARB_ROUND_ROBIN_EN for round-robin selection; default is fixed priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA = DEF_DATA,
    parameter int ADDR = DEF_ADDR,
    parameter int NREQ = DEF_NREQ
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ-1:0]            req_we,
    input  logic [NREQ-1:0][ADDR-1:0]  req_addr,
    input  logic [NREQ-1:0][DATA-1:0]  req_wdata,
    output logic [NREQ-1:0]            gnt,
    output logic [NREQ-1:0]            rvalid,
    output logic [DATA-1:0]            rdata,
    output logic                       busy,
    output logic [ADDR-1:0]            mem_addr,
    output logic [DATA-1:0]            mem_data_in,
    output logic                       mem_we,
    output logic                       mem_re,
    input  logic [DATA-1:0]            mem_data_out
);

    localparam int IDXW = $clog2(NREQ);

    arb_state_t      state_q, state_d;
    logic [NREQ-1:0] sel_oh, win_oh_q;
    logic [IDXW-1:0] sel_idx, ptr;
    logic            we_q;
    logic [ADDR-1:0] addr_q;
    logic [DATA-1:0] wdata_q;
    logic            capture;

    arb_select #(.NREQ(NREQ), .IDXW(IDXW)) u_select (
        .req     (req),
        .ptr     (ptr),
        .gnt_oh  (sel_oh),
        .gnt_idx (sel_idx)
    );

`ifdef ARB_ROUND_ROBIN_EN
    logic [IDXW-1:0] ptr_q;

    always_ff @(posedge clk) begin
        if (rst)
            ptr_q <= IDXW'(NREQ - 1);
        else if (capture)
            ptr_q <= sel_idx;
    end

    assign ptr = ptr_q;
`else
    // Searching upward from NREQ-1 wraps to index 0 first: lowest-index priority.
    assign ptr = IDXW'(NREQ - 1);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            win_oh_q <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                win_oh_q <= sel_oh;
                we_q     <= req_we[sel_idx];
                addr_q   <= req_addr[sel_idx];
                wdata_q  <= req_wdata[sel_idx];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        gnt     = '0;
        rvalid  = '0;
        rdata   = '0;
        mem_we  = 1'b0;
        mem_re  = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    capture = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                gnt     = win_oh_q;
                mem_we  = we_q;
                mem_re  = !we_q;
                state_d = we_q ? IDLE : RESP;
            end
            RESP: begin
                rvalid  = win_oh_q;
                rdata   = mem_data_out;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A reset cycle aborts the transaction outright: nothing leaves the block.
        if (rst) begin
            gnt    = '0;
            rvalid = '0;
            rdata  = '0;
            mem_we = 1'b0;
            mem_re = 1'b0;
        end
    end

    assign mem_addr    = addr_q;
    assign mem_data_in = wdata_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter against a timeline model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int DATA = 8;
    localparam int ADDR = 16;
    localparam int NREQ = 4;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NREQ-1:0]           req, req_we;
    logic [NREQ-1:0][ADDR-1:0] req_addr;
    logic [NREQ-1:0][DATA-1:0] req_wdata;
    logic [NREQ-1:0]           gnt, rvalid;
    logic [DATA-1:0]           rdata;
    logic                      busy;
    logic [ADDR-1:0]           mem_addr;
    logic [DATA-1:0]           mem_data_in;
    logic                      mem_we, mem_re;
    logic [DATA-1:0]           mem_data_out;

    mem_port_arbiter #(.DATA(DATA), .ADDR(ADDR), .NREQ(NREQ)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .gnt          (gnt),
        .rvalid       (rvalid),
        .rdata        (rdata),
        .busy         (busy),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_we       (mem_we),
        .mem_re       (mem_re),
        .mem_data_out (mem_data_out)
    );

    always #5 clk = ~clk;

    // Memory seen by the DUT: registered read, one cycle after mem_re.
    logic [DATA-1:0] tb_mem [0:(1<<ADDR)-1];
    initial begin
        for (int i = 0; i < (1 << ADDR); i++) tb_mem[i] = '0;
        mem_data_out = '0;
    end
    always @(posedge clk) begin
        if (mem_re) mem_data_out <= tb_mem[mem_addr];
        if (mem_we) tb_mem[mem_addr] <= mem_data_in;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: each accepted request occupies a fixed slice of the timeline.
    logic [DATA-1:0] ref_mem [0:(1<<ADDR)-1];
    int              cyc = 0;
    int              free_at = 0, gnt_at = -1, rv_at = -1;
    int              ptr = NREQ - 1;
    int              m_win = 0;
    logic            m_we = 1'b0;
    logic [ADDR-1:0] m_addr = '0, last_addr = '0;
    logic [DATA-1:0] m_wdata = '0, last_wdata = '0;

    function automatic int pick(input logic [NREQ-1:0] r, input int p);
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= NREQ; k++)
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
`else
        for (int k = 0; k < NREQ; k++)
            if (r[k]) return k;
`endif
        return 0;
    endfunction

    task automatic model_edge();
        if (rst) begin
            free_at = cyc + 1; gnt_at = -1; rv_at = -1; ptr = NREQ - 1;
            last_addr = '0; last_wdata = '0;
            return;
        end
        if (cyc == gnt_at && m_we) ref_mem[m_addr] = m_wdata;
        if (cyc >= free_at && req != '0) begin
            m_win   = pick(req, ptr);
            ptr     = m_win;
            m_we    = req_we[m_win];
            m_addr  = req_addr[m_win];
            m_wdata = req_wdata[m_win];
            last_addr  = m_addr;
            last_wdata = m_wdata;
            gnt_at  = cyc + 1;
            rv_at   = m_we ? -1 : cyc + 2;
            free_at = cyc + (m_we ? 2 : 3);
        end
    endtask

    task automatic check_outputs();
        logic [NREQ-1:0] oh;
        oh = '0;
        oh[m_win] = 1'b1;
        check_val("busy",        busy,        cyc < free_at);
        check_val("gnt",         gnt,         (cyc == gnt_at) ? oh : '0);
        check_val("mem_we",      mem_we,      (cyc == gnt_at) && m_we);
        check_val("mem_re",      mem_re,      (cyc == gnt_at) && !m_we);
        check_val("rvalid",      rvalid,      (cyc == rv_at) ? oh : '0);
        check_val("rdata",       rdata,       (cyc == rv_at) ? ref_mem[m_addr] : '0);
        check_val("mem_addr",    mem_addr,    last_addr);
        check_val("mem_data_in", mem_data_in, last_wdata);
    endtask

    // Requester side: hold req and payload until granted.
    logic [NREQ-1:0] pend = '0, hold_mask = '0;
    logic            p_we    [NREQ];
    logic [ADDR-1:0] p_addr  [NREQ];
    logic [DATA-1:0] p_wdata [NREQ];
    int              gq [$];

    task automatic set_pend(input int i, input logic we, input logic [ADDR-1:0] a, input logic [DATA-1:0] d);
        pend[i] = 1'b1; p_we[i] = we; p_addr[i] = a; p_wdata[i] = d;
    endtask

    task automatic apply_inputs();
        for (int i = 0; i < NREQ; i++) begin
            req[i] = pend[i];
            if (pend[i]) begin
                req_we[i] = p_we[i]; req_addr[i] = p_addr[i]; req_wdata[i] = p_wdata[i];
            end else begin
                req_we[i] = 1'($urandom); req_addr[i] = ADDR'($urandom); req_wdata[i] = DATA'($urandom);
            end
        end
    endtask

    task automatic post(input int i, input logic we, input logic [ADDR-1:0] a, input logic [DATA-1:0] d);
        set_pend(i, we, a, d);
        apply_inputs();
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check_outputs();
        if (rst) pend = '0;
        for (int i = 0; i < NREQ; i++)
            if (gnt[i]) begin pend[i] = 1'b0; gq.push_back(i); end
        for (int i = 0; i < NREQ; i++)
            if (hold_mask[i] && !pend[i]) set_pend(i, 1'b1, ADDR'(16'h0100 + i), DATA'($urandom));
        apply_inputs();
    endtask

    task automatic check_rst_gate(input string tag);
        #1;
        check_val({tag, "_gnt"},    gnt,    0);
        check_val({tag, "_rvalid"}, rvalid, 0);
        check_val({tag, "_rdata"},  rdata,  0);
        check_val({tag, "_we"},     mem_we, 0);
        check_val({tag, "_re"},     mem_re, 0);
    endtask

    function automatic logic [ADDR-1:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return '1;
        return ADDR'($urandom_range(0, 15));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int exp_seq [5];
        int idle_act;
        int cnt;
        int budget;
`ifdef ARB_ROUND_ROBIN_EN
        exp_seq = '{0, 1, 2, 3, 0};
`else
        exp_seq = '{0, 0, 0, 0, 0};
`endif
        for (int i = 0; i < (1 << ADDR); i++) ref_mem[i] = '0;

        rst = 1'b1;
        apply_inputs();
        tick();
        tick();
        check_val("rst_gnt",    gnt,         0);
        check_val("rst_rvalid", rvalid,      0);
        check_val("rst_rdata",  rdata,       0);
        check_val("rst_we",     mem_we,      0);
        check_val("rst_re",     mem_re,      0);
        check_val("rst_addr",   mem_addr,    0);
        check_val("rst_din",    mem_data_in, 0);
        check_val("rst_busy",   busy,        0);
        rst = 1'b0;
        apply_inputs();

        idle_act = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            idle_act += int'(busy) + int'(mem_we) + int'(mem_re) + int'(gnt != 0) + int'(rvalid != 0);
        end
        check_val("idle_quiet", idle_act, 0);

        post(1, 1'b1, 16'h0040, 8'hA5);
        tick();
        check_val("wr_gnt",  gnt,         4'b0010);
        check_val("wr_we",   mem_we,      1);
        check_val("wr_addr", mem_addr,    16'h0040);
        check_val("wr_data", mem_data_in, 8'hA5);
        tick();
        check_val("wr_we_once", mem_we, 0);

        post(2, 1'b0, 16'h0040, 8'h00);
        tick();
        check_val("rd_gnt", gnt,    4'b0100);
        check_val("rd_re",  mem_re, 1);
        tick();
        check_val("rd_rvalid", rvalid, 4'b0100);
        check_val("rd_rdata",  rdata,  8'hA5);
        tick();

        rst = 1'b1;
        apply_inputs();
        tick();
        rst = 1'b0;
        gq.delete();
        hold_mask = '1;
        for (int i = 0; i < NREQ; i++) set_pend(i, 1'b1, ADDR'(16'h0100 + i), DATA'($urandom));
        apply_inputs();
        budget = 0;
        while (gq.size() < 5 && budget < 40) begin tick(); budget++; end
        check_val("cont_timeout", gq.size() >= 5, 1);
        for (int k = 0; k < 5 && k < gq.size(); k++) check_val($sformatf("cont_order%0d", k), gq[k], exp_seq[k]);
        hold_mask[0] = 1'b0;
        pend[0] = 1'b0;
        apply_inputs();
        gq.delete();
        budget = 0;
        while (gq.size() < 1 && budget < 10) begin tick(); budget++; end
        check_val("cont_drop0", (gq.size() > 0) ? gq[0] : -1, 1);
        hold_mask = '0;
        pend = '0;
        apply_inputs();
        repeat (4) tick();

        post(2, 1'b0, 16'h0040, 8'h00);
        tick();
        tick();
        check_val("mid_in_resp", busy, 1);
        rst = 1'b1;
        check_rst_gate("mid_rst");
        tick();
        rst = 1'b0;
        apply_inputs();
        tick();
        check_val("mid_busy", busy, 0);
        post(3, 1'b1, 16'h0080, 8'h3C);
        tick();
        check_val("mid_next_gnt", gnt, 4'b1000);
        tick();

        hold_mask = 4'b0001;
        post(0, 1'b1, 16'h0100, DATA'($urandom));
        cnt = 0;
        for (int n = 0; n < 16; n++) begin
            tick();
            cnt += int'(gnt[0]);
        end
        check_val("b2b_count", cnt, 8);
        hold_mask = '0;
        pend = '0;
        apply_inputs();
        repeat (4) tick();

        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 249) == 0);
            for (int i = 0; i < NREQ; i++)
                if (!pend[i] && $urandom_range(0, 3) == 0)
                    set_pend(i, 1'($urandom), rand_addr(), DATA'($urandom));
            apply_inputs();
            if (rst) check_rst_gate("rnd_rst");
            tick();
        end
        rst = 1'b0;
        pend = '0;
        apply_inputs();
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
